// File: rtl/hazard_ctrl_if.sv
// Port bundle for the hazard controller: pipeline-register taps in, stall/flush/bypass
// controls and perf counters out. master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_W     = 16
);
  logic                 D_valid;
  logic [ADDR_SIZE-1:0] D_ra, D_rb;
  logic [ADDR_SIZE-1:0] EX_rd, MEM_rd, WB_rd;
  logic                 EX_we, MEM_we, WB_we;
  logic                 EX_ld, EX_mul, EX_br_taken;
  logic                 perf_clr;
  logic                 stall_F, stall_D, stall_EX, flush_D, bubble_EX;
  logic [1:0]           fwd_ra_sel, fwd_rb_sel;
  logic                 mul_busy;
  logic [CNT_W-1:0]     stall_cnt, flush_cnt;

  modport master (
    output D_valid, D_ra, D_rb, EX_rd, MEM_rd, WB_rd, EX_we, MEM_we, WB_we,
           EX_ld, EX_mul, EX_br_taken, perf_clr,
    input  stall_F, stall_D, stall_EX, flush_D, bubble_EX, fwd_ra_sel, fwd_rb_sel,
           mul_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  D_valid, D_ra, D_rb, EX_rd, MEM_rd, WB_rd, EX_we, MEM_we, WB_we,
           EX_ld, EX_mul, EX_br_taken, perf_clr,
    output stall_F, stall_D, stall_EX, flush_D, bubble_EX, fwd_ra_sel, fwd_rb_sel,
           mul_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-source bypass selection, load-use stall/bubble,
// branch flush, multiply occupancy FSM and saturating stall/flush counters.

// One bypass lane per D-stage source; stage order in rd/we is {WB, MEM, EX}.
module hazard_fwd_lane #(
  parameter int ADDR_SIZE = 5
) (
  input  logic                        valid,
  input  logic [ADDR_SIZE-1:0]        src,
  input  logic [2:0][ADDR_SIZE-1:0]   rd,
  input  logic [2:0]                  we,
  input  logic                        ex_ok,
  output logic                        ex_hit,
  output logic [1:0]                  sel
);
  logic [2:0] hit;

  for (genvar s = 0; s < 3; s++) begin : g_hit
    assign hit[s] = valid && we[s] && (rd[s] != '0) && (rd[s] == src);
  end

  // Raw EX hit feeds load-use detection even when EX can't forward.
  assign ex_hit = hit[0];

  always_comb begin
    sel = 2'b00;
    if      (hit[0] && ex_ok) sel = 2'b01;
    else if (hit[1])          sel = 2'b10;
    else if (hit[2])          sel = 2'b11;
  end
endmodule

module hazard_ctrl #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 5,
  parameter int MUL_LAT   = 3,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  localparam int                NUM_SRC   = 2;
  localparam int                MCNT_W    = 4;
  localparam bit                MUL_MULTI = (MUL_LAT > 1);
  localparam logic [MCNT_W-1:0] MCNT_INIT = MUL_MULTI ? MCNT_W'(MUL_LAT - 2) : '0;

  if (XLEN < 1 || MUL_LAT < 1 || MUL_LAT > 16) begin : g_bad_param
    $error("hazard_ctrl: MUL_LAT must be 1..16 and XLEN positive");
  end

  typedef enum logic {IDLE, BUSY} mul_state_e;

  mul_state_e                        state, state_nxt;
  logic [MCNT_W-1:0]                 mcnt, mcnt_nxt;
  logic                              mul_stall, lu, br;
  logic                              stall_d, flush_d, bubble_ex, busy;
  logic [NUM_SRC-1:0][ADDR_SIZE-1:0] src;
  logic [2:0][ADDR_SIZE-1:0]         stg_rd;
  logic [2:0]                        stg_we;
  logic [NUM_SRC-1:0]                ex_hit;
  logic [NUM_SRC-1:0][1:0]           fwd_sel;
  logic [CNT_W-1:0]                  stall_q, flush_q;

  // Multiply FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcnt  <= '0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  // Multiply FSM: next state; a new EX_mul while BUSY is deliberately ignored
  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    case (state)
      IDLE: if (hz.EX_mul && MUL_MULTI) begin
        state_nxt = BUSY;
        mcnt_nxt  = MCNT_INIT;
      end
      BUSY: if (mcnt == '0) state_nxt = IDLE;
            else            mcnt_nxt  = mcnt - MCNT_W'(1);
      default: state_nxt = IDLE;
    endcase
  end

  // Kept apart from the output block: the lanes consume it and feed ex_hit back.
  assign mul_stall = ((state == IDLE) && hz.EX_mul && MUL_MULTI) ||
                     ((state == BUSY) && (mcnt != '0));

  assign src    = {hz.D_rb, hz.D_ra};
  assign stg_rd = {hz.WB_rd, hz.MEM_rd, hz.EX_rd};
  assign stg_we = {hz.WB_we, hz.MEM_we, hz.EX_we};

  for (genvar l = 0; l < NUM_SRC; l++) begin : g_lane
    hazard_fwd_lane #(.ADDR_SIZE(ADDR_SIZE)) u_lane (
      .valid  (hz.D_valid),
      .src    (src[l]),
      .rd     (stg_rd),
      .we     (stg_we),
      .ex_ok  (!hz.EX_ld && !mul_stall),
      .ex_hit (ex_hit[l]),
      .sel    (fwd_sel[l])
    );
  end

  // Multiply FSM / hazard outputs; a taken branch overrides load-use
  always_comb begin
    busy      = (state == BUSY);
    lu        = hz.EX_ld && (|ex_hit);
    br        = hz.EX_br_taken && !mul_stall;
    stall_d   = mul_stall || (lu && !br);
    bubble_ex = lu && !br && !mul_stall;
    flush_d   = br;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (hz.perf_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_d && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_d && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.stall_F    = stall_d;
  assign hz.stall_D    = stall_d;
  assign hz.stall_EX   = mul_stall;
  assign hz.flush_D    = flush_d;
  assign hz.bubble_EX  = bubble_ex;
  assign hz.fwd_ra_sel = fwd_sel[0];
  assign hz.fwd_rb_sel = fwd_sel[1];
  assign hz.mul_busy   = busy;
  assign hz.stall_cnt  = stall_q;
  assign hz.flush_cnt  = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: three controllers (MUL_LAT 3/1/16, the last with 4-bit counters)
// share one input stream; expected values are hand-derived.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.ADDR_SIZE(5), .CNT_W(16)) ia ();
  hazard_ctrl_if #(.ADDR_SIZE(5), .CNT_W(16)) ib ();
  hazard_ctrl_if #(.ADDR_SIZE(5), .CNT_W(4))  ic ();

  assign {ib.D_valid,     ic.D_valid}     = {2{ia.D_valid}};
  assign {ib.D_ra,        ic.D_ra}        = {2{ia.D_ra}};
  assign {ib.D_rb,        ic.D_rb}        = {2{ia.D_rb}};
  assign {ib.EX_rd,       ic.EX_rd}       = {2{ia.EX_rd}};
  assign {ib.MEM_rd,      ic.MEM_rd}      = {2{ia.MEM_rd}};
  assign {ib.WB_rd,       ic.WB_rd}       = {2{ia.WB_rd}};
  assign {ib.EX_we,       ic.EX_we}       = {2{ia.EX_we}};
  assign {ib.MEM_we,      ic.MEM_we}      = {2{ia.MEM_we}};
  assign {ib.WB_we,       ic.WB_we}       = {2{ia.WB_we}};
  assign {ib.EX_ld,       ic.EX_ld}       = {2{ia.EX_ld}};
  assign {ib.EX_mul,      ic.EX_mul}      = {2{ia.EX_mul}};
  assign {ib.EX_br_taken, ic.EX_br_taken} = {2{ia.EX_br_taken}};
  assign {ib.perf_clr,    ic.perf_clr}    = {2{ia.perf_clr}};

  hazard_ctrl #(.MUL_LAT(3),  .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .hz(ia.slave));
  hazard_ctrl #(.MUL_LAT(1),  .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .hz(ib.slave));
  hazard_ctrl #(.MUL_LAT(16), .CNT_W(4))  dut_c (.clk(clk), .rst(rst), .hz(ic.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int nst   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    ia.D_valid = 1'b1; ia.D_ra = '0; ia.D_rb = '0;
    ia.EX_rd = '0; ia.MEM_rd = '0; ia.WB_rd = '0;
    ia.EX_we = 1'b0; ia.MEM_we = 1'b0; ia.WB_we = 1'b0;
    ia.EX_ld = 1'b0; ia.EX_mul = 1'b0; ia.EX_br_taken = 1'b0; ia.perf_clr = 1'b0;
  endtask

  task automatic lu_in();
    ia.EX_ld = 1'b1; ia.EX_we = 1'b1; ia.EX_rd = 5'd7; ia.D_rb = 5'd7;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    @(negedge clk); #1;
    chk("rst_stall_cnt", ia.stall_cnt, 0);
    chk("rst_flush_cnt", ia.flush_cnt, 0);
    chk("rst_mul_busy",  ia.mul_busy, 0);
    chk("rst_stall_EX",  ia.stall_EX, 0);
    lu_in(); #1;
    chk("rst_comb_lu_stall", ia.stall_D, 1);

    // forwarding priority
    @(negedge clk); rst = 1'b0; idle_in();
    ia.D_ra = 5; ia.D_rb = 5; ia.EX_rd = 5; ia.MEM_rd = 5; ia.WB_rd = 5;
    ia.EX_we = 1; ia.MEM_we = 1; ia.WB_we = 1; #1;
    chk("prio_ex_ra", ia.fwd_ra_sel, 2'b01);
    chk("prio_ex_rb", ia.fwd_rb_sel, 2'b01);
    @(negedge clk); ia.EX_we = 0; #1;
    chk("prio_mem_ra", ia.fwd_ra_sel, 2'b10);
    chk("prio_mem_rb", ia.fwd_rb_sel, 2'b10);
    @(negedge clk); ia.MEM_we = 0; #1;
    chk("prio_wb_ra", ia.fwd_ra_sel, 2'b11);
    @(negedge clk); ia.EX_rd = 0; ia.MEM_rd = 0; ia.WB_rd = 0; ia.EX_we = 1; ia.MEM_we = 1; #1;
    chk("prio_x0_ra", ia.fwd_ra_sel, 2'b00);
    chk("prio_x0_rb", ia.fwd_rb_sel, 2'b00);
    @(negedge clk); ia.EX_rd = 5; ia.D_valid = 0; #1;
    chk("prio_invalid_ra", ia.fwd_ra_sel, 2'b00);

    // load-use: one stall cycle, then MEM forwards
    @(negedge clk); idle_in(); lu_in(); ia.D_ra = 3; #1;
    chk("lu_stall_F",  ia.stall_F, 1);
    chk("lu_stall_D",  ia.stall_D, 1);
    chk("lu_bubble",   ia.bubble_EX, 1);
    chk("lu_rb_sel",   ia.fwd_rb_sel, 2'b00);
    chk("lu_stall_EX", ia.stall_EX, 0);
    @(negedge clk); idle_in(); ia.MEM_we = 1; ia.MEM_rd = 7; ia.D_ra = 3; ia.D_rb = 7; #1;
    chk("lu_next_rb_sel",  ia.fwd_rb_sel, 2'b10);
    chk("lu_next_stall_D", ia.stall_D, 0);
    chk("lu_stall_cnt",    ia.stall_cnt, 1);

    // multiply at t with dependent D instruction
    @(negedge clk); idle_in(); ia.EX_mul = 1; ia.EX_we = 1; ia.EX_rd = 9; ia.D_ra = 9; #1;
    nst += int'(ic.stall_EX);
    chk("mul_t0_stall_EX", ia.stall_EX, 1);
    chk("mul_t0_busy",     ia.mul_busy, 0);
    chk("mul_t0_fwd",      ia.fwd_ra_sel, 2'b00);
    chk("lat1_stall_EX",   ib.stall_EX, 0);
    chk("lat1_fwd",        ib.fwd_ra_sel, 2'b01);
    @(negedge clk); ia.EX_mul = 0; #1;
    nst += int'(ic.stall_EX);
    chk("mul_t1_stall_EX", ia.stall_EX, 1);
    chk("mul_t1_busy",     ia.mul_busy, 1);
    chk("mul_t1_stall_F",  ia.stall_F, 1);
    chk("mul_t1_fwd",      ia.fwd_ra_sel, 2'b00);
    @(negedge clk); #1;
    nst += int'(ic.stall_EX);
    chk("mul_t2_stall_EX", ia.stall_EX, 0);
    chk("mul_t2_busy",     ia.mul_busy, 1);
    chk("mul_t2_fwd",      ia.fwd_ra_sel, 2'b01);
    chk("mul_t2_stall_D",  ia.stall_D, 0);
    @(negedge clk); idle_in(); #1;
    nst += int'(ic.stall_EX);
    chk("mul_t3_busy", ia.mul_busy, 0);
    for (int i = 4; i <= 20; i++) begin
      @(negedge clk); #1;
      nst += int'(ic.stall_EX);
      if (i == 15) chk("lat16_t15_busy", ic.mul_busy, 1);
      if (i == 16) chk("lat16_t16_busy", ic.mul_busy, 0);
    end
    chk("lat16_stall_cycles", nst, 15);
    chk("mul_a_stall_cnt", ia.stall_cnt, 3);
    chk("mul_b_stall_cnt", ib.stall_cnt, 1);
    chk("mul_c_stall_sat", ic.stall_cnt, 15);

    // taken branch inside the multiply stall window is ignored
    @(negedge clk); idle_in(); ia.EX_mul = 1;
    @(negedge clk); ia.EX_mul = 0; ia.EX_br_taken = 1; #1;
    chk("busy_br_flush",   ia.flush_D, 0);
    chk("busy_br_stall_F", ia.stall_F, 1);
    chk("lat1_br_flush",   ib.flush_D, 1);
    @(negedge clk); idle_in();
    repeat (16) @(negedge clk);
    #1;
    chk("busy_br_a_flush_cnt", ia.flush_cnt, 0);
    chk("busy_br_b_flush_cnt", ib.flush_cnt, 1);
    chk("busy_br_a_stall_cnt", ia.stall_cnt, 5);

    // branch beats load-use
    @(negedge clk); idle_in(); lu_in(); ia.EX_br_taken = 1; #1;
    chk("brlu_flush",   ia.flush_D, 1);
    chk("brlu_stall_D", ia.stall_D, 0);
    chk("brlu_stall_F", ia.stall_F, 0);
    chk("brlu_bubble",  ia.bubble_EX, 0);
    @(negedge clk); idle_in(); #1;
    chk("brlu_flush_cnt", ia.flush_cnt, 1);
    chk("brlu_stall_cnt", ia.stall_cnt, 5);

    // reset in the second stall cycle of a multiply
    @(negedge clk); ia.EX_mul = 1;
    @(negedge clk); ia.EX_mul = 0; #1;
    chk("pre_rst_busy",     ia.mul_busy, 1);
    chk("pre_rst_stall_EX", ia.stall_EX, 1);
    rst = 1'b1; #1;
    chk("mid_rst_stall_EX",  ia.stall_EX, 0);
    chk("mid_rst_busy",      ia.mul_busy, 0);
    chk("mid_rst_stall_cnt", ia.stall_cnt, 0);
    chk("mid_rst_flush_cnt", ia.flush_cnt, 0);
    chk("mid_rst_c_stall",   ic.stall_EX, 0);

    // 2^4+3 stall cycles saturate the 4-bit counter
    @(negedge clk); rst = 1'b0; idle_in(); lu_in();
    repeat (19) @(negedge clk);
    idle_in(); #1;
    chk("sat_c_stall_cnt", ic.stall_cnt, 15);
    chk("sat_a_stall_cnt", ia.stall_cnt, 19);
    chk("sat_b_stall_cnt", ib.stall_cnt, 19);

    // perf_clr wins over a simultaneous increment
    @(negedge clk); lu_in(); ia.perf_clr = 1;
    @(negedge clk); idle_in(); #1;
    chk("clr_a_stall_cnt", ia.stall_cnt, 0);
    chk("clr_c_stall_cnt", ic.stall_cnt, 0);
    chk("clr_b_flush_cnt", ib.flush_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Second-generation pipeline hazard controller for the 5-stage core. It generates forwarding selects, the load-use stall and bubble, and a branch/jump flush. It also runs a multi-cycle multiplier occupancy FSM that holds the front end while a multiply sits in EX. It sits beside the D stage: it takes register indices and control bits from the D/EX/MEM/WB pipeline registers and drives the stall/flush enables and the D-stage bypass muxes.

## Interface
- XLEN, 32, datapath width (carried for consistency; no datapath logic inside)
- ADDR_SIZE, 5, register index width
- MUL_LAT, 3, total EX-stage cycles a multiply occupies; legal range 1..16
- CNT_W, 16, width of the performance counters
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- D_valid  in  1  D stage holds a real instruction
- D_ra, D_rb  in  ADDR_SIZE  D-stage source registers
- EX_rd, MEM_rd, WB_rd  in  ADDR_SIZE  destination registers per stage
- EX_we, MEM_we, WB_we  in  1  stage writes its rd
- EX_ld  in  1  EX instruction is a load
- EX_mul  in  1  EX instruction is a multiply
- EX_br_taken  in  1  branch/jump resolved taken in EX
- perf_clr  in  1  synchronous clear of both counters
- stall_F, stall_D  out  1  hold PC and F/D
- stall_EX  out  1  hold D/EX and EX
- flush_D  out  1  squash F/D contents
- bubble_EX  out  1  load NOP into D/EX
- fwd_ra_sel, fwd_rb_sel  out  2  00 regfile, 01 EX, 10 MEM, 11 WB
- mul_busy  out  1  FSM in BUSY
- stall_cnt, flush_cnt  out  CNT_W  saturating perf counters

## Operation
- Hit definition: a stage hits a source when stage_we=1, stage_rd != 0, stage_rd == source, and D_valid=1. Register x0 never hits.
- Forward priority is EX > MEM > WB, per source independently.
- EX is not eligible as a forward source when EX_ld=1 or mul_stall=1. In that case the next eligible stage wins.
- Load-use: lu = EX_ld && (EX hit on ra || EX hit on rb).
- Multiply FSM:
  - States IDLE and BUSY, plus down-counter mcnt.
  - IDLE with EX_mul=1 and MUL_LAT>1: go to BUSY, mcnt <= MUL_LAT-2.
  - BUSY: mcnt decrements while nonzero.
  - BUSY with mcnt==0: return to IDLE. EX_mul is ignored in BUSY.
  - mul_stall = (IDLE && EX_mul && MUL_LAT>1) || (BUSY && mcnt!=0).
  - MUL_LAT=1: FSM never leaves IDLE and mul_stall is 0.
- Output equations:
  - stall_EX = mul_stall
  - br = EX_br_taken && !mul_stall
  - stall_F = stall_D = mul_stall || (lu && !br)
  - bubble_EX = lu && !br && !mul_stall
  - flush_D = br
- On a branch, bubble_EX is not used to kill the D instruction; the pipeline's flush wiring clears D/EX on br.
- Counters:
  - stall_cnt +1 on every cycle with stall_D=1.
  - flush_cnt +1 on every cycle with flush_D=1.
  - Both saturate at all-ones.
  - perf_clr=1 forces both to 0, with priority over increment.

## Timing
- Reset (async) values: FSM IDLE, mcnt 0, stall_cnt 0, flush_cnt 0.
- Outputs during reset are then purely combinational from inputs.
- Reset mid-multiply drops mul_busy and mul_stall immediately.
- All stall, flush, bubble and fwd outputs are combinational, with the same-cycle decision.
- Only mcnt, the FSM state and the counters are registered.
- Multiply with MUL_LAT=N starting in cycle t:
  - stall_EX=1 in cycles t..t+N-2.
  - mul_busy=1 in cycles t+1..t+N-1.
  - EX is eligible as a forward source in cycle t+N-1.
  - FSM is IDLE at t+N, where a back-to-back multiply may start.
- Load-use stalls exactly one cycle: the next cycle sees a bubble in EX, and the load moves to MEM and forwards from MEM.
- Simultaneous lu and br: br wins, so no stall and no bubble, flush only.
- Counter updates appear the cycle after the event.

## Test plan
- **Priority:** D_ra=5, D_rb=5, with EX, MEM and WB all writing r5 (EX_ld=0) -> fwd_ra_sel=fwd_rb_sel=01. Repeat with EX_we=0 -> 10. Repeat with rd=0 in all stages -> 00.
- **Load-use:** EX_ld=1, EX_rd=7, D_rb=7 -> stall_F=stall_D=bubble_EX=1 and fwd_rb_sel≠01 for one cycle. Next cycle MEM_rd=7 -> fwd_rb_sel=10 and no stall. stall_cnt reads 1.
- **Multiply, MUL_LAT=3:** EX_mul pulse sequence -> stall_EX=1 for 2 cycles, mul_busy high for cycles 2–3, and EX forwarding to a dependent D instruction is enabled only in the third cycle. Rerun with MUL_LAT=1 -> no stall. Rerun with MUL_LAT=16 -> 15 stall cycles.
- **Branch vs load-use:** EX_br_taken=1 together with a load-use hit -> flush_D=1, stall_D=0, bubble_EX=0, and flush_cnt increments. EX_br_taken during the BUSY stall window -> ignored.
- **Reset and counters:** assert rst in the second stall cycle of a multiply -> stall_EX=0 and mul_busy=0 in the same cycle, counters 0. Drive 2^CNT_W+3 stall cycles -> stall_cnt holds all-ones. perf_clr -> 0.
